log_frame_sequencer: RTL and testbench

- Sequences the streaming log stage of the log-mel spectrogram pipeline.
- Accepts power-spectrum samples over a valid/ready stream and drives the log datapath's input side: data, di_en, bin index (in_group_idx), frame number (in_group_num), and is_first_in/is_last_in flags.
- Tracks outstanding samples inside the log pipeline through a credit counter fed by do_en, counts returned outputs per frame, and reports frame and spectrogram completion.

---
 rtl/log_frame_sequencer.sv | 158 +++++++++++++++
 tb/tb_log_frame_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/log_frame_sequencer.sv
// Issue/return sequencer for the streaming log stage of the log-mel pipeline.
// Issues one sample per handshake with bin/frame tags and tracks in-flight work by credits.
module log_frame_sequencer #(
    parameter int I_BW         = 14,
    parameter int BINS         = 513,
    parameter int FRAMES       = 89,
    parameter int MAX_INFLIGHT = 8,
    parameter int IDX_W        = $clog2(BINS),
    parameter int NUM_W        = $clog2(FRAMES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [I_BW-1:0]  s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic signed [I_BW-1:0]  log_data_i,
    output logic                    log_di_en,
    output logic [IDX_W-1:0]        log_in_group_idx,
    output logic [NUM_W-1:0]        log_in_group_num,
    output logic                    log_is_first_in,
    output logic                    log_is_last_in,
    input  logic                    log_do_en,
    output logic                    busy,
    output logic                    frame_done,
    output logic [NUM_W-1:0]        out_frame_num,
    output logic                    done,
    output logic                    err
);

    localparam int CW = $clog2(MAX_INFLIGHT) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BINS - 1);
    localparam logic [NUM_W-1:0] LAST_NUM = NUM_W'(FRAMES - 1);
    localparam logic [CW-1:0]    MAX_CRED = CW'(MAX_INFLIGHT);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDX_W-1:0]  r_iss_idx;
    logic [NUM_W-1:0]  r_iss_num;
    logic [IDX_W-1:0]  r_out_idx;
    logic [NUM_W-1:0]  r_out_frame;
    logic              r_out_all;
    logic [CW-1:0]     r_cred;
    logic [CW-1:0]     w_cred_nxt;

    logic w_hs;
    logic w_do_ok;
    logic w_do_bad;
    logic w_cnt_out;
    logic w_frame_end;
    logic w_last_out;
    logic w_last_iss;

    assign s_ready = (r_state == S_RUN) && (r_cred < MAX_CRED);
    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_DONE);

    assign w_hs        = s_valid && s_ready;
    // A return is legitimate only if something is in flight (or issuing this cycle).
    assign w_do_ok     = log_do_en && ((r_cred != '0) || w_hs);
    assign w_do_bad    = log_do_en && (r_cred == '0) && !w_hs;
    assign w_cnt_out   = w_do_ok && ((r_state == S_RUN) || (r_state == S_DRAIN));
    assign w_frame_end = w_cnt_out && (r_out_idx == LAST_IDX);
    assign w_last_out  = w_frame_end && (r_out_frame == LAST_NUM);
    assign w_last_iss  = w_hs && (r_iss_idx == LAST_IDX) && (r_iss_num == LAST_NUM);

    always_comb begin
        w_cred_nxt = r_cred;
        if (w_hs && !log_do_en)
            w_cred_nxt = r_cred + CW'(1);
        else if (!w_hs && w_do_ok)
            w_cred_nxt = r_cred - CW'(1);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last_iss) w_state_nxt = S_DRAIN;
            // Leave on the edge that retires the final output so done lines up with its frame_done.
            S_DRAIN: if ((w_cred_nxt == '0) && (w_last_out || r_out_all)) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            log_data_i       <= '0;
            log_di_en        <= 1'b0;
            log_in_group_idx <= '0;
            log_in_group_num <= '0;
            log_is_first_in  <= 1'b0;
            log_is_last_in   <= 1'b0;
            frame_done       <= 1'b0;
            out_frame_num    <= '0;
            err              <= 1'b0;
            r_iss_idx        <= '0;
            r_iss_num        <= '0;
            r_out_idx        <= '0;
            r_out_frame      <= '0;
            r_out_all        <= 1'b0;
            r_cred           <= '0;
        end else begin
            log_di_en  <= w_hs;
            frame_done <= w_frame_end;
            r_cred     <= w_cred_nxt;

            if (w_hs) begin
                log_data_i       <= s_data;
                log_in_group_idx <= r_iss_idx;
                log_in_group_num <= r_iss_num;
                log_is_first_in  <= (r_iss_idx == '0);
                log_is_last_in   <= (r_iss_idx == LAST_IDX);
                if (r_iss_idx == LAST_IDX) begin
                    r_iss_idx <= '0;
                    r_iss_num <= (r_iss_num == LAST_NUM) ? '0 : r_iss_num + NUM_W'(1);
                end else begin
                    r_iss_idx <= r_iss_idx + IDX_W'(1);
                end
            end

            if (w_frame_end) begin
                out_frame_num <= r_out_frame;
                r_out_idx     <= '0;
                r_out_frame   <= (r_out_frame == LAST_NUM) ? '0 : r_out_frame + NUM_W'(1);
                if (w_last_out)
                    r_out_all <= 1'b1;
            end else if (w_cnt_out) begin
                r_out_idx <= r_out_idx + IDX_W'(1);
            end

            if (w_do_bad)
                err <= 1'b1;

            // A fresh run always begins from bin 0 / frame 0 with clean bookkeeping.
            if ((r_state == S_IDLE) && start) begin
                err         <= 1'b0;
                r_iss_idx   <= '0;
                r_iss_num   <= '0;
                r_out_idx   <= '0;
                r_out_frame <= '0;
                r_out_all   <= 1'b0;
                r_cred      <= '0;
            end
        end
    end

endmodule

// File: tb/tb_log_frame_sequencer.sv
// Directed bench for log_frame_sequencer: three instances (small, low-credit, full size)
// each driving a fixed-latency model of the log datapath.
module tb_log_frame_sequencer;
    localparam int I_BW = 14;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- instance a: 4 bins x 2 frames, 8 credits, latency 3
    logic rst_a = 1'b1, start_a = 1'b0, sv_a = 1'b0, inj_a = 1'b0;
    logic signed [I_BW-1:0] sd_a = '0, ld_a;
    logic srdy_a, di_a, first_a, last_a, busy_a, fd_a, done_a, err_a, do_a;
    logic [1:0] idx_a;
    logic [0:0] num_a, ofn_a;
    logic [2:0] pipe_a = '0;
    always @(posedge clk) pipe_a <= {pipe_a[1:0], di_a};
    assign do_a = pipe_a[2] | inj_a;

    log_frame_sequencer #(.I_BW(I_BW), .BINS(4), .FRAMES(2), .MAX_INFLIGHT(8)) u_a (
        .clk(clk), .rst(rst_a), .start(start_a), .s_data(sd_a), .s_valid(sv_a), .s_ready(srdy_a),
        .log_data_i(ld_a), .log_di_en(di_a), .log_in_group_idx(idx_a), .log_in_group_num(num_a),
        .log_is_first_in(first_a), .log_is_last_in(last_a), .log_do_en(do_a), .busy(busy_a),
        .frame_done(fd_a), .out_frame_num(ofn_a), .done(done_a), .err(err_a));

    int a_iq[$], a_fl[$], a_dq[$], a_tq[$], a_fq[$], a_acc[$];
    int a_fd_t = -1, a_done_t = -1, a_idle_t = -1, a_done_n = 0, a_coinc = 0;
    int m_cred_a = 0;
    logic a_busy_q = 1'b0;

    always @(negedge clk) begin
        int t;
        bit hs;
        t = int'($time / 10);
        hs = sv_a && srdy_a;
        if (di_a) begin
            a_iq.push_back(int'(idx_a) + 10 * int'(num_a));
            a_fl.push_back(2 * int'(first_a) + int'(last_a));
            a_dq.push_back(int'(ld_a));
            a_tq.push_back(t);
        end
        if (fd_a) begin a_fq.push_back(int'(ofn_a)); a_fd_t = t; end
        if (done_a) begin a_done_n++; a_done_t = t; end
        if (a_busy_q && !busy_a) a_idle_t = t;
        a_busy_q = busy_a;
        if (hs) a_acc.push_back(int'(sd_a));
        if (hs && do_a) a_coinc++;
        chk("a_cred", 32'(u_a.r_cred), m_cred_a);
        // credit model for the value after the coming edge
        if (rst_a || (start_a && !busy_a))
            m_cred_a = 0;
        else
            m_cred_a = m_cred_a + (hs ? 1 : 0) - ((do_a && (m_cred_a > 0 || hs)) ? 1 : 0);
    end

    // ---------------- instance b: 4 bins x 2 frames, 2 credits, latency 6
    logic start_b = 1'b0, sv_b = 1'b0, b_on = 1'b0;
    logic signed [I_BW-1:0] sd_b = '0, ld_b;
    logic srdy_b, di_b, first_b, last_b, busy_b, fd_b, done_b, err_b, do_b;
    logic [1:0] idx_b;
    logic [0:0] num_b, ofn_b;
    logic [5:0] pipe_b = '0;
    logic rst_b = 1'b1;
    always @(posedge clk) pipe_b <= {pipe_b[4:0], di_b};
    assign do_b = pipe_b[5];

    log_frame_sequencer #(.I_BW(I_BW), .BINS(4), .FRAMES(2), .MAX_INFLIGHT(2)) u_b (
        .clk(clk), .rst(rst_b), .start(start_b), .s_data(sd_b), .s_valid(sv_b), .s_ready(srdy_b),
        .log_data_i(ld_b), .log_di_en(di_b), .log_in_group_idx(idx_b), .log_in_group_num(num_b),
        .log_is_first_in(first_b), .log_is_last_in(last_b), .log_do_en(do_b), .busy(busy_b),
        .frame_done(fd_b), .out_frame_num(ofn_b), .done(done_b), .err(err_b));

    int b_iq[$];
    int b_done_n = 0, iss_b = 0, m_cred_b = 0;

    always @(negedge clk) begin
        bit hs;
        hs = sv_b && srdy_b;
        if (di_b) b_iq.push_back(int'(idx_b) + 10 * int'(num_b));
        if (done_b) b_done_n++;
        if (b_on) begin
            chk("b_ready", 32'(srdy_b), (iss_b < 8 && m_cred_b < 2) ? 1 : 0);
            chk("b_cred_max", (u_b.r_cred <= 2) ? 1 : 0, 1);
        end
        if (hs) iss_b++;
        m_cred_b = m_cred_b + (hs ? 1 : 0) - ((do_b && (m_cred_b > 0 || hs)) ? 1 : 0);
    end

    // ---------------- instance c: default 513 x 89, latency 4
    logic rst_c = 1'b1, start_c = 1'b0, sv_c = 1'b0;
    logic signed [I_BW-1:0] sd_c = '0, ld_c;
    logic srdy_c, di_c, first_c, last_c, busy_c, fd_c, done_c, err_c, do_c;
    logic [9:0] idx_c;
    logic [6:0] num_c, ofn_c;
    logic [3:0] pipe_c = '0;
    always @(posedge clk) pipe_c <= {pipe_c[2:0], di_c};
    assign do_c = pipe_c[3];

    log_frame_sequencer #(.I_BW(I_BW)) u_c (
        .clk(clk), .rst(rst_c), .start(start_c), .s_data(sd_c), .s_valid(sv_c), .s_ready(srdy_c),
        .log_data_i(ld_c), .log_di_en(di_c), .log_in_group_idx(idx_c), .log_in_group_num(num_c),
        .log_is_first_in(first_c), .log_is_last_in(last_c), .log_do_en(do_c), .busy(busy_c),
        .frame_done(fd_c), .out_frame_num(ofn_c), .done(done_c), .err(err_c));

    int c_seq_bad = 0, c_n = 0, c_last = 0, c_fd = 0, c_outs = 0, c_done_outs = -1;
    int e_idx = 0, e_num = 0;

    always @(negedge clk) begin
        if (di_c) begin
            if (int'(idx_c) != e_idx || int'(num_c) != e_num ||
                first_c != (e_idx == 0) || last_c != (e_idx == 512)) c_seq_bad++;
            c_n++;
            if (last_c) c_last++;
            if (e_idx == 512) begin e_idx = 0; e_num++; end
            else e_idx++;
        end
        if (fd_c) begin
            if (int'(ofn_c) != c_fd) c_seq_bad++;
            c_fd++;
        end
        if (done_c && c_done_outs < 0) c_done_outs = c_outs;
        if (do_c) c_outs++;
    end

    // ---------------- stimulus helpers
    task automatic chk_zero_a(input string tag);
        chk({tag, "_ctl"}, {24'd0, srdy_a, di_a, first_a, last_a, busy_a, fd_a, done_a, err_a}, 0);
        chk({tag, "_fld"}, {14'd0, idx_a, num_a, ofn_a, ld_a}, 0);
    endtask

    task automatic drive_a(input bit rnd, input bit mid_start);
        int acc;
        bit hs;
        a_iq.delete(); a_fl.delete(); a_dq.delete(); a_tq.delete(); a_fq.delete(); a_acc.delete();
        a_done_n = 0; a_coinc = 0; a_fd_t = -1; a_done_t = -1; a_idle_t = -1;
        acc = 0; sd_a = '0; sv_a = 1'b1;
        tick(); start_a = 1'b1;
        tick(); start_a = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            hs = sv_a && srdy_a;
            tick();
            if (hs) begin acc++; sd_a = I_BW'(acc); end
            sv_a = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start_a = mid_start && hs && (acc == 3);
        end
        sv_a = 1'b0; start_a = 1'b0;
    endtask

    task automatic check_a_run(input string tag, input bit back_to_back);
        chk({tag, "_ndi"}, a_iq.size(), 8);
        chk({tag, "_nacc"}, a_acc.size(), 8);
        for (int k = 0; k < 8 && k < a_iq.size(); k++) begin
            chk({tag, "_idxnum"}, a_iq[k], (k % 4) + 10 * (k / 4));
            chk({tag, "_fl"}, a_fl[k], (k % 4 == 0) ? 2 : ((k % 4 == 3) ? 1 : 0));
            chk({tag, "_data"}, a_dq[k], k);
            if (k < a_acc.size()) chk({tag, "_data_acc"}, a_dq[k], a_acc[k]);
            if (back_to_back) chk({tag, "_b2b"}, a_tq[k] - a_tq[0], k);
        end
        chk({tag, "_nfd"}, a_fq.size(), 2);
        if (a_fq.size() == 2) begin
            chk({tag, "_ofn0"}, a_fq[0], 0);
            chk({tag, "_ofn1"}, a_fq[1], 1);
        end
        chk({tag, "_ndone"}, a_done_n, 1);
        chk({tag, "_done_t"}, a_done_t, a_fd_t);
        chk({tag, "_idle_t"}, a_idle_t, a_done_t + 1);
        chk({tag, "_err"}, 32'(err_a), 0);
    endtask

    initial begin
        bit found;
        tick(); tick();
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        @(negedge clk);
        chk_zero_a("rst");

        // basic run with a start pulse mid-run that must be ignored
        drive_a(1'b0, 1'b1);
        check_a_run("a", 1'b1);
        chk("a_coinc_seen", (a_coinc > 0) ? 1 : 0, 1);

        // random valid gaps
        drive_a(1'b1, 1'b0);
        check_a_run("rnd", 1'b0);

        // low credit limit
        iss_b = 0;
        sv_b = 1'b1;
        tick(); start_b = 1'b1;
        tick(); start_b = 1'b0; b_on = 1'b1;
        for (int c = 0; c < 80; c++) tick();
        b_on = 1'b0; sv_b = 1'b0;
        chk("b_ndi", b_iq.size(), 8);
        for (int k = 0; k < 8 && k < b_iq.size(); k++) chk("b_idxnum", b_iq[k], (k % 4) + 10 * (k / 4));
        chk("b_ndone", b_done_n, 1);
        chk("b_err", 32'(err_b), 0);

        // stray return in IDLE, then reset mid-run
        tick(); inj_a = 1'b1;
        tick(); inj_a = 1'b0;
        @(negedge clk);
        chk("idle_do_err", 32'(err_a), 1);
        sv_a = 1'b1;
        tick(); start_a = 1'b1;
        tick(); start_a = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (di_a && idx_a == 2'd2) begin found = 1'b1; break; end
        end
        chk("bin2_seen", 32'(found), 1);
        tick(); rst_a = 1'b1; sv_a = 1'b0;
        tick(); rst_a = 1'b0;
        @(negedge clk);
        chk_zero_a("midrst");
        for (int i = 0; i < 8; i++) tick();
        chk("late_do_err", 32'(err_a), 1);
        drive_a(1'b0, 1'b0);
        check_a_run("restart", 1'b1);

        // full-size spectrogram
        sv_c = 1'b1;
        tick(); start_c = 1'b1;
        tick(); start_c = 1'b0;
        for (int i = 0; i < 47000 && c_done_outs < 0; i++) @(negedge clk);
        sv_c = 1'b0;
        chk("c_ndi", c_n, 45657);
        chk("c_seq", c_seq_bad, 0);
        chk("c_last", c_last, 89);
        chk("c_nfd", c_fd, 89);
        chk("c_done_outs", c_done_outs, 45657);
        chk("c_err", 32'(err_c), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
